// File: rtl/debounce_pkg.sv
// debounce_pkg
// Shared defaults, the counter-width helper and the per-channel output bundle
// for the debounce_bank block and its debounce_channel sub-module.
// Optional feature macro: DEBOUNCE_LONGPRESS_EN (long-press hold detector).
package debounce_pkg;

   localparam int DEF_N_CH        = 4;
   localparam int DEF_CNT_MAX     = 20000;
   localparam int DEF_ON_TH       = 15000;
   localparam int DEF_OFF_TH      = 5000;
   localparam int DEF_HOLD_CYCLES = 2000000;

   // Bits needed to hold values 0..max inclusive.
   function automatic int cnt_w(input int max);
      return (max < 1) ? 1 : $clog2(max + 1);
   endfunction

   typedef struct packed {
      logic lvl;
      logic rise;
      logic fall;
      logic hold;
      logic held;
   } ch_out_t;

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel
// One debounce channel: two-flop synchroniser, saturating up/down integrator,
// hysteresis level, registered rise/fall pulses and, when DEBOUNCE_LONGPRESS_EN
// is defined, a long-press hold detector. With the macro undefined the hold
// outputs are constant 0 and no hold logic exists.
// Ports:
//   clk     - clock
//   rst     - synchronous active-low reset
//   btn_in  - raw asynchronous input, active high
//   ch_out  - registered {lvl, rise, fall, hold, held}
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int CNT_MAX     = DEF_CNT_MAX,
   parameter int ON_TH       = DEF_ON_TH,
   parameter int OFF_TH      = DEF_OFF_TH,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    btn_in,
   output ch_out_t ch_out
);

   localparam int            CW        = cnt_w(CNT_MAX);
   localparam logic [CW-1:0] CNT_MAX_C = CW'(CNT_MAX);
   localparam logic [CW-1:0] ON_TH_C   = CW'(ON_TH);
   localparam logic [CW-1:0] OFF_TH_C  = CW'(OFF_TH);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   logic          s1_q, s2_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          lvl_q, lvl_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;

   // Level is decided from the next count so the level, its edge pulse and
   // the count that crossed the threshold all land on the same clock edge.
   always_comb begin
      cnt_d = cnt_q;
      if (s2_q && (cnt_q < CNT_MAX_C)) begin
         cnt_d = cnt_q + CNT_ONE;
      end else if (!s2_q && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_ONE;
      end

      lvl_d = lvl_q;
      if (cnt_d >= ON_TH_C) begin
         lvl_d = 1'b1;
      end else if (cnt_d <= OFF_TH_C) begin
         lvl_d = 1'b0;
      end

      rise_d = lvl_d & ~lvl_q;
      fall_d = ~lvl_d & lvl_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         cnt_q  <= '0;
         lvl_q  <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         s1_q   <= btn_in;
         s2_q   <= s1_q;
         cnt_q  <= cnt_d;
         lvl_q  <= lvl_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

`ifdef DEBOUNCE_LONGPRESS_EN
   localparam int            HW       = cnt_w(HOLD_CYCLES);
   localparam logic [HW-1:0] HOLD_C   = HW'(HOLD_CYCLES);
   localparam logic [HW-1:0] HOLD_ONE = HW'(1);

   logic [HW-1:0] hcnt_q, hcnt_d;
   logic          hold_q, hold_d;
   logic          held_q, held_d;

   // Counting starts on the first cycle btn_lvl is visible high, so the hold
   // pulse lands HOLD_CYCLES cycles after the rise pulse. Held is qualified
   // by the next level so it drops on the same edge as the fall pulse.
   always_comb begin
      hcnt_d = '0;
      if (lvl_q) begin
         hcnt_d = (hcnt_q < HOLD_C) ? (hcnt_q + HOLD_ONE) : hcnt_q;
      end
      held_d = lvl_d && (hcnt_d == HOLD_C);
      hold_d = held_d && (hcnt_q != HOLD_C);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         hcnt_q <= '0;
         hold_q <= 1'b0;
         held_q <= 1'b0;
      end else begin
         hcnt_q <= hcnt_d;
         hold_q <= hold_d;
         held_q <= held_d;
      end
   end

   assign ch_out = {lvl_q, rise_q, fall_q, hold_q, held_q};
`else
   // Hold length is still validated so enabling the feature later cannot
   // expose a bad configuration.
   if (HOLD_CYCLES < 1) begin : g_bad_hold
      $fatal(1, "debounce_channel: HOLD_CYCLES must be at least 1");
   end

   assign ch_out = {lvl_q, rise_q, fall_q, 2'b00};
`endif

endmodule

// File: rtl/debounce_bank.sv
// debounce_bank
// Bank of N_CH independent debouncers for mechanical inputs. All outputs are
// registered; there is no combinational path from btn_in to any output.
// Optional feature macro: DEBOUNCE_LONGPRESS_EN (long-press hold/held outputs;
// tied to 0 when undefined).
// Ports:
//   clk       - clock
//   rst       - synchronous active-low reset
//   btn_in    - raw asynchronous inputs, active high
//   btn_lvl   - debounced level
//   btn_rise  - one-cycle pulse on btn_lvl 0->1
//   btn_fall  - one-cycle pulse on btn_lvl 1->0
//   btn_hold  - one-cycle long-press pulse
//   btn_held  - long-press level
module debounce_bank
   import debounce_pkg::*;
#(
   parameter int N_CH        = DEF_N_CH,
   parameter int CNT_MAX     = DEF_CNT_MAX,
   parameter int ON_TH       = DEF_ON_TH,
   parameter int OFF_TH      = DEF_OFF_TH,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] btn_in,
   output logic [N_CH-1:0] btn_lvl,
   output logic [N_CH-1:0] btn_rise,
   output logic [N_CH-1:0] btn_fall,
   output logic [N_CH-1:0] btn_hold,
   output logic [N_CH-1:0] btn_held
);

   if ((N_CH < 1) || (OFF_TH < 0) || (OFF_TH >= ON_TH) || (ON_TH > CNT_MAX)
       || (HOLD_CYCLES < 1)) begin : g_bad_params
      $fatal(1, "debounce_bank: illegal parameter set");
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      ch_out_t ch_out;

      debounce_channel #(
         .CNT_MAX     (CNT_MAX),
         .ON_TH       (ON_TH),
         .OFF_TH      (OFF_TH),
         .HOLD_CYCLES (HOLD_CYCLES)
      ) u_ch (
         .clk    (clk),
         .rst    (rst),
         .btn_in (btn_in[i]),
         .ch_out (ch_out)
      );

      assign btn_lvl[i]  = ch_out.lvl;
      assign btn_rise[i] = ch_out.rise;
      assign btn_fall[i] = ch_out.fall;
      assign btn_hold[i] = ch_out.hold;
      assign btn_held[i] = ch_out.held;
   end

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank
// Directed bench for debounce_bank with N_CH=4, CNT_MAX=15, ON_TH=10,
// OFF_TH=5, HOLD_CYCLES=40. Hold/held expectations follow whether
// DEBOUNCE_LONGPRESS_EN is defined for the build.
module tb_debounce_bank;

`ifdef DEBOUNCE_LONGPRESS_EN
   localparam int LP = 1;
`else
   localparam int LP = 0;
`endif

   logic       clk;
   logic       rst;
   logic [3:0] btn_in;
   logic [3:0] btn_lvl, btn_rise, btn_fall, btn_hold, btn_held;

   debounce_bank #(
      .N_CH        (4),
      .CNT_MAX     (15),
      .ON_TH       (10),
      .OFF_TH      (5),
      .HOLD_CYCLES (40)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_in   (btn_in),
      .btn_lvl  (btn_lvl),
      .btn_rise (btn_rise),
      .btn_fall (btn_fall),
      .btn_hold (btn_hold),
      .btn_held (btn_held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   both_n  = 0;
   int   rise_n [4];
   int   fall_n [4];
   int   hold_n [4];
   int   rise_cyc [4];
   int   hold_cyc [4];
   logic held_prev [4];
   logic held_at_fall [4];
   logic held_before_fall [4];
   logic [19:0] out_or;
   logic [3:0]  lvl_or;

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      for (int c = 0; c < 4; c++) begin
         rise_n[c] = 0; fall_n[c] = 0; hold_n[c] = 0;
         rise_cyc[c] = 0; hold_cyc[c] = 0;
         held_prev[c] = 1'b0; held_at_fall[c] = 1'b0; held_before_fall[c] = 1'b0;
      end
      both_n = 0;
      out_or = '0;
      lvl_or = '0;
   endtask

   // Advance n clocks, sampling 1 time unit after each rising edge.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         cyc++;
         out_or = out_or | {btn_lvl, btn_rise, btn_fall, btn_hold, btn_held};
         lvl_or = lvl_or | btn_lvl;
         for (int c = 0; c < 4; c++) begin
            if (btn_rise[c]) begin rise_n[c]++; rise_cyc[c] = cyc; end
            if (btn_fall[c]) begin
               fall_n[c]++;
               held_at_fall[c]     = btn_held[c];
               held_before_fall[c] = held_prev[c];
            end
            if (btn_hold[c]) begin hold_n[c]++; hold_cyc[c] = cyc; end
            if (btn_rise[c] && btn_fall[c]) both_n++;
            held_prev[c] = btn_held[c];
         end
      end
   endtask

   task automatic pulse_reset();
      rst = 1'b0;
      step(1);
      rst = 1'b1;
   endtask

   int fall_tot;

   initial begin
      rst    = 1'b0;
      btn_in = 4'hF;
      clear_stats();

      // Reset held for 3 cycles with all inputs high.
      step(3);
      check_val("rst_outputs_zero", 32'(out_or), 32'h0);
      rst = 1'b1;
      step(11);
      check_val("rst_lvl_before", 32'(btn_lvl), 32'h0);
      step(1);
      check_val("rst_lvl_after", 32'(btn_lvl), 32'hF);
      check_val("rst_rise", 32'(btn_rise), 32'hF);
      step(1);
      check_val("rst_rise_one_cycle", 32'(btn_rise), 32'h0);

      btn_in = 4'h0;
      pulse_reset();
      clear_stats();
      step(2);

      // Clean press and release on channel 0.
      btn_in[0] = 1'b1;
      step(11);
      check_val("c0_lvl_before", 32'(btn_lvl[0]), 32'h0);
      step(1);
      check_val("c0_lvl_rise", 32'(btn_lvl[0]), 32'h1);
      check_val("c0_rise_pulse", 32'(btn_rise[0]), 32'h1);
      step(18);
      btn_in[0] = 1'b0;
      step(11);
      check_val("c0_lvl_before_fall", 32'(btn_lvl[0]), 32'h1);
      step(1);
      check_val("c0_lvl_fall", 32'(btn_lvl[0]), 32'h0);
      check_val("c0_fall_pulse", 32'(btn_fall[0]), 32'h1);
      step(1);
      check_val("c0_fall_one_cycle", 32'(btn_fall[0]), 32'h0);
      check_val("c0_rise_count", 32'(rise_n[0]), 32'd1);
      check_val("c0_fall_count", 32'(fall_n[0]), 32'd1);
      check_val("c0_short_no_hold", 32'(hold_n[0]), 32'd0);

      // Bounce on channel 1: 3 high / 3 low for 60 cycles.
      lvl_or = '0;
      for (int p = 0; p < 10; p++) begin
         btn_in[1] = 1'b1;
         step(3);
         btn_in[1] = 1'b0;
         step(3);
      end
      check_val("c1_bounce_lvl", 32'(lvl_or[1]), 32'h0);
      check_val("c1_bounce_rise", 32'(rise_n[1]), 32'd0);
      check_val("c1_bounce_fall", 32'(fall_n[1]), 32'd0);
      btn_in[1] = 1'b1;
      step(11);
      check_val("c1_steady_before", 32'(btn_lvl[1]), 32'h0);
      step(1);
      check_val("c1_steady_rise", 32'(btn_rise[1]), 32'h1);
      btn_in[1] = 1'b0;
      step(20);

      // Hysteresis on channel 3: dip to cnt=7 holds level, dip to 5 drops it.
      btn_in[3] = 1'b1;
      step(30);
      check_val("c3_lvl_sat", 32'(btn_lvl[3]), 32'h1);
      btn_in[3] = 1'b0;
      step(8);
      btn_in[3] = 1'b1;
      step(20);
      check_val("c3_hyst_lvl", 32'(btn_lvl[3]), 32'h1);
      check_val("c3_hyst_no_fall", 32'(fall_n[3]), 32'd0);
      btn_in[3] = 1'b0;
      step(11);
      check_val("c3_cnt6_lvl", 32'(btn_lvl[3]), 32'h1);
      step(1);
      check_val("c3_cnt5_fall", 32'(btn_fall[3]), 32'h1);
      check_val("c3_rise_count", 32'(rise_n[3]), 32'd1);
      step(5);

      // Long press on channel 2 for 100 cycles.
      btn_in[2] = 1'b1;
      step(100);
      check_val("c2_held_mid", 32'(btn_held[2]), 32'(LP));
      btn_in[2] = 1'b0;
      step(20);
      check_val("c2_hold_count", 32'(hold_n[2]), 32'(LP));
      check_val("c2_hold_cycle", 32'(hold_cyc[2]), 32'(LP * (rise_cyc[2] + 40)));
      check_val("c2_fall_count", 32'(fall_n[2]), 32'd1);
      check_val("c2_held_before_fall", 32'(held_before_fall[2]), 32'(LP));
      check_val("c2_held_at_fall", 32'(held_at_fall[2]), 32'h0);
      check_val("c2_held_after", 32'(btn_held[2]), 32'h0);

      // Mid-press reset with all channels at level 1.
      btn_in = 4'hF;
      step(30);
      check_val("mid_lvl_pre", 32'(btn_lvl), 32'hF);
      fall_tot = fall_n[0] + fall_n[1] + fall_n[2] + fall_n[3];
      pulse_reset();
      check_val("mid_outputs_zero",
                32'({btn_lvl, btn_rise, btn_fall, btn_hold, btn_held}), 32'h0);
      step(11);
      check_val("mid_lvl_before", 32'(btn_lvl), 32'h0);
      check_val("mid_no_fall", 32'(fall_n[0] + fall_n[1] + fall_n[2] + fall_n[3]),
                32'(fall_tot));
      step(1);
      check_val("mid_lvl_after", 32'(btn_lvl), 32'hF);
      check_val("mid_rise_all", 32'(btn_rise), 32'hF);

      check_val("rise_fall_exclusive", 32'(both_n), 32'd0);
      check_val("other_no_hold", 32'(hold_n[0] + hold_n[1] + hold_n[3]), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
